// File: rtl/p_mul_drv.sv
// Queues multiply commands and issues them one at a time to the packed multiplier, returning tagged results.
// Accept at t -> mul_valid at t+2; mul_ready at u -> rsp_valid at u+1; cmd_ready drops when full or faulted, issue stalls on an unconsumed response.

module p_mul_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)     rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

module p_mul_drv #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [4:0]       cmd_pw,
   input  logic [31:0]      cmd_rs1,
   input  logic [31:0]      cmd_rs2,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             mul_valid,
   input  logic             mul_ready,
   output logic             mul_l,
   output logic             mul_h,
   output logic             clmul,
   output logic [4:0]       mul_pw,
   output logic [31:0]      mul_crs1,
   output logic [31:0]      mul_crs2,
   input  logic [31:0]      mul_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             fault
);
   typedef struct packed {
      logic [1:0]       op;
      logic [4:0]       pw;
      logic [31:0]      rs1;
      logic [31:0]      rs2;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, FAULT} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = 1;

   state_t           state, state_nxt;
   cmd_t             push_cmd, head;
   logic             fifo_full, fifo_empty, pop;
   logic [CW-1:0]    cnt;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_load, cnt_clr, cnt_inc, fault_set;
   logic             rsp_load, rsp_err_nxt;
   logic [31:0]      rsp_result_nxt;
   logic [TAG_W-1:0] rsp_tag_nxt;

   // Held low through the reset cycle itself, not just after it.
   assign cmd_ready = !fifo_full && !fault && !reset;

   assign push_cmd = '{op: cmd_op, pw: cmd_pw, rs1: cmd_rs1, rs2: cmd_rs2, tag: cmd_tag};

   p_mul_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (cmd_valid && cmd_ready),
      .push_dat (push_cmd),
      .pop      (pop),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      pop            = 1'b0;
      issue_load     = 1'b0;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      fault_set      = 1'b0;
      rsp_load       = 1'b0;
      rsp_err_nxt    = 1'b0;
      rsp_result_nxt = '0;
      rsp_tag_nxt    = issue_tag;
      case (state)
         IDLE: begin
            // The response slot must be free, or freed this cycle, before a pop.
            if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
               pop     = 1'b1;
               cnt_clr = 1'b1;
               if (head.op == 2'b11) begin
                  rsp_load    = 1'b1;
                  rsp_err_nxt = 1'b1;
                  rsp_tag_nxt = head.tag;
               end else begin
                  issue_load = 1'b1;
                  state_nxt  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (mul_ready) begin
               rsp_load       = 1'b1;
               rsp_result_nxt = mul_result;
               state_nxt      = IDLE;
            end else if (cnt == CNT_LAST) begin
               rsp_load    = 1'b1;
               rsp_err_nxt = 1'b1;
               fault_set   = 1'b1;
               state_nxt   = FAULT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         FAULT:   state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mul_valid  <= 1'b0;
         mul_l      <= 1'b0;
         mul_h      <= 1'b0;
         clmul      <= 1'b0;
         mul_pw     <= '0;
         mul_crs1   <= '0;
         mul_crs2   <= '0;
         issue_tag  <= '0;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_tag    <= '0;
         rsp_err    <= 1'b0;
         fault      <= 1'b0;
      end else begin
         mul_valid <= (state_nxt == ISSUE);
         if (issue_load) begin
            mul_l     <= (head.op == 2'b00);
            mul_h     <= (head.op == 2'b01);
            clmul     <= (head.op == 2'b10);
            mul_pw    <= head.pw;
            mul_crs1  <= head.rs1;
            mul_crs2  <= head.rs2;
            issue_tag <= head.tag;
         end
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CNT_ONE;
         if (rsp_load) begin
            rsp_valid  <= 1'b1;
            rsp_result <= rsp_result_nxt;
            rsp_tag    <= rsp_tag_nxt;
            rsp_err    <= rsp_err_nxt;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (fault_set) fault <= 1'b1;
      end
   end
endmodule

// File: tb/tb_p_mul_drv.sv
// Directed bench for p_mul_drv with a behavioural multiplier responder.
module tb_p_mul_drv;
   localparam int TAG_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_op;
   logic [4:0]       cmd_pw;
   logic [31:0]      cmd_rs1, cmd_rs2;
   logic [TAG_W-1:0] cmd_tag;
   logic             mul_valid, mul_ready;
   logic             mul_l, mul_h, clmul;
   logic [4:0]       mul_pw;
   logic [31:0]      mul_crs1, mul_crs2, mul_result;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err, fault;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_cyc = 0;
   int resp_lat = 0;
   bit resp_en = 1'b1;
   int wait_cnt = 0;

   p_mul_drv #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pw(cmd_pw),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_tag(cmd_tag),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_l(mul_l), .mul_h(mul_h), .clmul(clmul),
      .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2), .mul_result(mul_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err), .fault(fault)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [1:0] op, input logic [4:0] pw, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
      cmd_valid = 1'b1; cmd_op = op; cmd_pw = pw; cmd_rs1 = a; cmd_rs2 = b; cmd_tag = tag;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Waits (bounded) for a response, checks it, then advances one cycle.
   task automatic get_rsp(input string name, input logic [TAG_W-1:0] etag,
                          input logic [31:0] eres, input logic eerr);
      int n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      chk({name, "_vld"}, rsp_valid, 1);
      chk({name, "_tag"}, rsp_tag, etag);
      chk({name, "_res"}, rsp_result, eres);
      chk({name, "_err"}, rsp_err, eerr);
      tick();
   endtask

   // Behavioural multiplier: answers resp_lat cycles after mul_valid is seen.
   initial begin
      logic [63:0] prod;
      mul_ready = 1'b0;
      mul_result = '0;
      forever begin
         @(posedge clock);
         #2;
         mul_ready = 1'b0;
         if (mul_valid && resp_en) begin
            if (wait_cnt >= resp_lat) begin
               prod = 64'(mul_crs1) * 64'(mul_crs2);
               mul_result = mul_h ? prod[63:32] : (clmul ? (mul_crs1 ^ mul_crs2) : prod[31:0]);
               mul_ready = 1'b1;
               ready_cyc = cyc;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      int n;
      int mv;
      bit unstable;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_pw = '0; cmd_rs1 = '0; cmd_rs2 = '0;
      cmd_tag = '0; rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_ctl", {mul_valid, mul_l, mul_h, clmul, mul_pw, rsp_valid, rsp_err, fault, rsp_tag}, 0);
      chk("rst_dat", {mul_crs1, mul_crs2}, 0);
      chk("rst_res", rsp_result, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // single mul_l, responder waits 3 cycles
      resp_lat = 3;
      push(2'b00, 5'b00001, 32'd3, 32'd5, 4'd2);
      chk("t1_no_issue_yet", mul_valid, 0);
      tick();
      chk("t1_issue_lat", mul_valid, 1);
      chk("t1_decode", {mul_l, mul_h, clmul, mul_pw}, {3'b100, 5'b00001});
      chk("t1_ops", {mul_crs1, mul_crs2}, {32'd3, 32'd5});
      unstable = 1'b0;
      n = 0;
      while (!rsp_valid && n < 30) begin
         if (mul_valid && ({mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2} !== {3'b100, 5'b00001, 32'd3, 32'd5}))
            unstable = 1'b1;
         tick();
         n++;
      end
      chk("t1_stable", unstable, 0);
      chk("t1_rsp_vld", rsp_valid, 1);
      chk("t1_rsp_lat", cyc - ready_cyc, 1);
      chk("t1_rsp", {rsp_result, 28'd0, rsp_tag, 3'd0, rsp_err}, {32'd15, 28'd0, 4'd2, 4'd0});
      chk("t1_mul_drop", mul_valid, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t1_consumed", rsp_valid, 0);

      // illegal op never reaches the multiplier
      push(2'b11, 5'b00010, 32'd9, 32'd9, 4'd7);
      chk("ill_t1_vld", {mul_valid, rsp_valid}, 0);
      tick();
      chk("ill_t2_vld", rsp_valid, 1);
      chk("ill_rsp", {rsp_err, rsp_tag, rsp_result}, {1'b1, 4'd7, 32'd0});
      chk("ill_no_mul", mul_valid, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("ill_consumed", rsp_valid, 0);

      // fill: 4 queued + 1 in flight, then in-order drain
      resp_lat = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fill_rdy%0d", i), cmd_ready, 1);
         push(2'b00, 5'b00001, 32'(i + 1), 32'd10, 4'(i));
      end
      chk("fill_full", cmd_ready, 0);
      cmd_valid = 1'b1; cmd_tag = 4'd5; cmd_op = 2'b00;
      tick();
      tick();
      chk("fill_still_full", cmd_ready, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++)
         get_rsp($sformatf("fill%0d", i), 4'(i), 32'((i + 1) * 10), 1'b0);
      for (int i = 0; i < 6; i++) tick();
      chk("fill_no_extra", {rsp_valid, mul_valid}, 0);
      chk("fill_drained", cmd_ready, 1);
      rsp_ready = 1'b0;

      // backpressure: second issue waits for consumption
      push(2'b01, 5'b00100, 32'h0001_0000, 32'h0003_0000, 4'd8);
      push(2'b10, 5'b01000, 32'h0000_00F0, 32'h0000_000F, 4'd9);
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      mv = 0;
      for (int i = 0; i < 10; i++) begin
         if (mul_valid) mv++;
         tick();
      end
      chk("bp_no_issue", mv, 0);
      chk("bp_hold", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd8, 32'd3});
      rsp_ready = 1'b1;
      get_rsp("bp_first", 4'd8, 32'd3, 1'b0);
      get_rsp("bp_second", 4'd9, 32'h0000_00FF, 1'b0);
      rsp_ready = 1'b0;

      // reset during ISSUE flushes everything
      resp_en = 1'b0;
      push(2'b00, 5'b00001, 32'd2, 32'd2, 4'd3);
      push(2'b00, 5'b00001, 32'd4, 32'd4, 4'd4);
      chk("rst_issue_active", mul_valid, 1);
      reset = 1'b1;
      tick();
      chk("rst_issue_drop", {mul_valid, rsp_valid}, 0);
      reset = 1'b0;
      resp_en = 1'b1;
      mv = 0;
      for (int i = 0; i < 4; i++) begin
         if (mul_valid) mv++;
         tick();
      end
      chk("rst_fifo_empty", mv, 0);
      chk("rst_rdy_again", cmd_ready, 1);
      rsp_ready = 1'b1;
      push(2'b00, 5'b00001, 32'd6, 32'd7, 4'd5);
      get_rsp("rst_new", 4'd5, 32'd42, 1'b0);
      rsp_ready = 1'b0;

      // timeout after 8 ISSUE cycles, sticky fault
      resp_en = 1'b0;
      push(2'b00, 5'b00001, 32'd1, 32'd1, 4'd6);
      tick();
      n = 0;
      while (mul_valid && n < 100) begin n++; tick(); end
      chk("to_cycles", n, 8);
      chk("to_rsp", {rsp_valid, rsp_err, rsp_tag, rsp_result}, {1'b1, 1'b1, 4'd6, 32'd0});
      chk("to_fault", {fault, cmd_ready, mul_valid}, 3'b100);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      resp_en = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tag = 4'd1;
      mv = 0;
      for (int i = 0; i < 5; i++) begin
         if (mul_valid) mv++;
         tick();
      end
      cmd_valid = 1'b0;
      chk("to_drained", rsp_valid, 0);
      chk("to_held", {fault, cmd_ready}, 2'b10);
      chk("to_no_issue", mv, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("to_reset_clear", {fault, cmd_ready, mul_valid, rsp_valid}, 4'b0100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/p_mul_drv.md
# p_mul_drv

Request-side driver for the packed multiplier's valid/ready operand interface. It queues multiply commands from a producer in a small FIFO and issues them one at a time to the multiplier, holding each request stable until the multiplier completes. It returns each result, with its tag, through a one-entry response register, and guards every issue with a timeout. It sits between the co-processor decode/issue stage and the packed multiplier, and is the initiator for the multiplier's `valid`/`ready` protocol.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `TAG_W`, 4: width of the opaque command tag.
- `TIMEOUT`, 64: maximum cycles in ISSUE before a fault; 1..1023.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  producer presents a command.
- `cmd_ready`  out  1  command accepted this cycle when both `cmd_valid` and `cmd_ready` are high.
- `cmd_op`  in  2  operation: 00 `mul_l`, 01 `mul_h`, 10 `clmul`, 11 illegal.
- `cmd_pw`  in  5  pack-width one-hot, passed through unchanged.
- `cmd_rs1`, `cmd_rs2`  in  32 each  operands.
- `cmd_tag`  in  TAG_W  returned with the response.
- `mul_valid`  out  1  request to the multiplier.
- `mul_ready`  in  1  multiplier completes; `mul_result` is valid this cycle.
- `mul_l`, `mul_h`, `clmul`  out  1 each  one-hot decode of the issued op.
- `mul_pw`  out  5  pack width of the issued op.
- `mul_crs1`, `mul_crs2`  out  32 each  issued operands.
- `mul_result`  in  32  multiplier result.
- `rsp_valid`  out  1  response held until consumed.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  32  result; 0 on error.
- `rsp_tag`  out  TAG_W  tag of the command that produced the response.
- `rsp_err`  out  1  illegal op or timeout.
- `fault`  out  1  sticky timeout flag; cleared only by `reset`.

## Operation
- FIFO:
  - `cmd_ready = !full && !fault`; no bypass.
  - A push is visible at the head on the next cycle.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full means the pointers match in index and differ in MSB; empty means the pointers are equal.
  - Push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, FAULT.
- IDLE:
  - Acts only when the FIFO is non-empty and `rsp_valid == 0`, or when `rsp_valid && rsp_ready` in that cycle.
  - In that case it pops the head into the issue registers and clears the timeout counter.
  - Legal op: go to ISSUE.
  - Illegal op (11): load the response directly with `rsp_err=1`, `rsp_result=0`, and the tag; stay in IDLE; the multiplier is never driven.
- ISSUE:
  - `mul_valid=1`; `mul_l`/`mul_h`/`clmul`/`mul_pw`/`mul_crs*` are constant from the issue registers.
  - On `mul_ready`: capture `mul_result` and the tag into the response register (`rsp_err=0`), set `rsp_valid`, go to IDLE.
  - Otherwise increment the counter (width clog2(TIMEOUT+1)).
- Timeout: when the counter reaches TIMEOUT-1 and `mul_ready==0`, the driver:
  - loads a response with `rsp_err=1` and result 0;
  - sets `fault`;
  - goes to FAULT.
- FAULT: `mul_valid=0` and `cmd_ready=0`; the pending response can still drain; exit only through `reset`.
- Response register: `rsp_valid` clears on `rsp_ready` unless it is reloaded in the same cycle.
- `mul_ready` outside ISSUE is ignored.

## Timing
- Reset values:
  - `cmd_ready=0` during the reset cycle, then 1.
  - `mul_valid=0`; `mul_l=mul_h=clmul=0`; `mul_pw=0`; `mul_crs1=mul_crs2=0`.
  - `rsp_valid=0`; `rsp_result=0`; `rsp_tag=0`; `rsp_err=0`; `fault=0`.
  - FIFO empty; state IDLE.
- All outputs are registered except `cmd_ready`, which is decoded combinationally from registered state.
- Latency:
  - Command accepted at cycle t; popped at t+1; `mul_valid=1` at t+2.
  - `mul_ready` at cycle u gives `rsp_valid=1` at u+1.
  - Illegal op accepted at t gives `rsp_valid` at t+2.
- Throughput: with `rsp_ready` tied high and `mul_ready` on the first ISSUE cycle, one command every 2 cycles.
- Reset mid-ISSUE: `mul_valid` drops on the next edge, and the FIFO and response are flushed. The multiplier must share this reset.

## Test plan
- Single `mul_l`: pw=5'b00001, rs1=3, rs2=5, tag=2; bench responder returns `ready` after 3 cycles with 15. Required response: `rsp_valid` with result 15, tag 2, err 0, exactly 1 cycle after `mul_ready`; operands stable throughout ISSUE.
- Fill: push 5 commands back-to-back with `rsp_ready=0` and DEPTH=4. Required response: `cmd_ready` low after 4 accepted commands plus 1 in flight; tags return in order 0..4 once `rsp_ready` rises.
- Illegal op 11, tag 7. Required response: `mul_valid` never rises; `rsp_err=1`, result 0, tag 7 at cycle t+2.
- Timeout with TIMEOUT=8 and a responder that never asserts `ready`. Required response: after 8 ISSUE cycles, `rsp_err=1`, `fault=1`, `cmd_ready=0`; state held until `reset`.
- Backpressure: `rsp_ready` low for 10 cycles with 2 queued commands. Required response: second issue waits until the response is consumed, with no loss or reorder.
- Reset during ISSUE. Required response: next cycle `mul_valid=0`, `rsp_valid=0`, FIFO empty; a new command issues normally afterward.
